// File: rtl/snake_step_ctrl_pkg.sv
// snake_step_ctrl_pkg: shared direction codes, FSM states and default geometry for the snake step sequencer.
//   Provides dir_e (00 up, 01 right, 10 down, 11 left), state_e, *_DEF geometry defaults
//   and opposite(), which returns the reverse heading.
package snake_step_ctrl_pkg;

   localparam int XW_DEF      = 6;
   localparam int YW_DEF      = 5;
   localparam int GRID_W_DEF  = 40;
   localparam int GRID_H_DEF  = 30;
   localparam int MAX_LEN_DEF = 64;
   localparam int LW_DEF      = 7;
   localparam int START_X_DEF = 20;
   localparam int START_Y_DEF = 15;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_COMMIT,
      ST_OVER,
      ST_CLEAR
   } state_e;

   // Reverse heading: the vertical pair and the horizontal pair differ only in bit 1.
   function automatic dir_e opposite(input dir_e d);
      return dir_e'(d ^ 2'b10);
   endfunction

endpackage

// File: rtl/snake_step_ctrl_next_cell.sv
// snake_step_ctrl_next_cell: combinational next head cell and wall detection.
//   head_x_i/head_y_i : current head cell
//   heading_i         : direction of travel
//   next_x_o/next_y_o : candidate cell (meaningful only when wall_o=0)
//   wall_o            : the move would leave the grid
module snake_step_ctrl_next_cell
   import snake_step_ctrl_pkg::*;
#(
   parameter int XW     = XW_DEF,
   parameter int YW     = YW_DEF,
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF
) (
   input  logic [XW-1:0] head_x_i,
   input  logic [YW-1:0] head_y_i,
   input  dir_e          heading_i,
   output logic [XW-1:0] next_x_o,
   output logic [YW-1:0] next_y_o,
   output logic          wall_o
);

   localparam logic [XW:0] ONE_X = 1;
   localparam logic [YW:0] ONE_Y = 1;

   logic [XW:0] wide_x;
   logic [YW:0] wide_y;

   // One extra bit makes 0-1 wrap to a huge value, so a single upper-bound
   // compare catches both the low and the high wall on each axis.
   always_comb begin
      wide_x   = heading_i == DIR_RIGHT ? {1'b0, head_x_i} + ONE_X :
                 heading_i == DIR_LEFT  ? {1'b0, head_x_i} - ONE_X : {1'b0, head_x_i};
      wide_y   = heading_i == DIR_DOWN  ? {1'b0, head_y_i} + ONE_Y :
                 heading_i == DIR_UP    ? {1'b0, head_y_i} - ONE_Y : {1'b0, head_y_i};
      wall_o   = (wide_x >= (XW+1)'(GRID_W)) || (wide_y >= (YW+1)'(GRID_H));
      next_x_o = wide_x[XW-1:0];
      next_y_o = wide_y[YW-1:0];
   end

endmodule

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: per-step game sequencer driving the occupancy map and body FIFO.
//   Inputs : clk, reset_n (async, active-low), step_req, dir, restart, apple_xy,
//            self_hit_now (valid while map_tick), body_count
//   Outputs: head_xy, next_x/next_y, map_tick/map_eat/map_will_pop, tail_valid,
//            body_push/body_pop, body_din, sub_clear, apple_eaten, game_over, busy
module snake_step_ctrl
   import snake_step_ctrl_pkg::*;
#(
   parameter int XW      = XW_DEF,
   parameter int YW      = YW_DEF,
   parameter int GRID_W  = GRID_W_DEF,
   parameter int GRID_H  = GRID_H_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int LW      = LW_DEF,
   parameter int START_X = START_X_DEF,
   parameter int START_Y = START_Y_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            step_req,
   input  logic [1:0]      dir,
   input  logic            restart,
   input  logic [XW+YW-1:0] apple_xy,
   input  logic            self_hit_now,
   input  logic [LW-1:0]   body_count,
   output logic [XW+YW-1:0] head_xy,
   output logic [XW-1:0]   next_x,
   output logic [YW-1:0]   next_y,
   output logic            map_tick,
   output logic            map_eat,
   output logic            map_will_pop,
   output logic            tail_valid,
   output logic            body_push,
   output logic            body_pop,
   output logic [XW+YW-1:0] body_din,
   output logic            sub_clear,
   output logic            apple_eaten,
   output logic            game_over,
   output logic            busy
);

   state_e        state_q;
   dir_e          heading_q, heading_d;
   logic [XW-1:0] head_x_q, next_x_q, cand_x;
   logic [YW-1:0] head_y_q, next_y_q, cand_y;
   logic [LW-1:0] len_q;
   logic          wall, eat_d, grow_d;
   logic          eat_q, map_tick_q, map_eat_q, map_will_pop_q, body_push_q;
   logic          apple_eaten_q, game_over_q, sub_clear_q;

   snake_step_ctrl_next_cell #(
      .XW     (XW),
      .YW     (YW),
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_next_cell (
      .head_x_i  (head_x_q),
      .head_y_i  (head_y_q),
      .heading_i (heading_q),
      .next_x_o  (cand_x),
      .next_y_o  (cand_y),
      .wall_o    (wall)
   );

   // A reversal request would fold the snake onto itself, so it keeps the heading.
   // Growth is refused once the body is full; the eat then degrades to a plain move.
   always_comb begin
      heading_d = dir_e'(dir) == opposite(heading_q) ? heading_q : dir_e'(dir);
      eat_d     = {cand_x, cand_y} == apple_xy;
      grow_d    = eat_d && (len_q < LW'(MAX_LEN));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         heading_q      <= DIR_RIGHT;
         head_x_q       <= XW'(START_X);
         head_y_q       <= YW'(START_Y);
         next_x_q       <= XW'(START_X);
         next_y_q       <= YW'(START_Y);
         len_q          <= '0;
         eat_q          <= 1'b0;
         map_tick_q     <= 1'b0;
         map_eat_q      <= 1'b0;
         map_will_pop_q <= 1'b0;
         body_push_q    <= 1'b0;
         apple_eaten_q  <= 1'b0;
         game_over_q    <= 1'b0;
         sub_clear_q    <= 1'b0;
      end else begin
         map_tick_q     <= 1'b0;
         map_eat_q      <= 1'b0;
         map_will_pop_q <= 1'b0;
         body_push_q    <= 1'b0;
         apple_eaten_q  <= 1'b0;
         sub_clear_q    <= 1'b0;
         if (restart) begin
            state_q     <= ST_CLEAR;
            sub_clear_q <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (step_req) begin
                     heading_q <= heading_d;
                     state_q   <= ST_CALC;
                  end
               end
               ST_CALC: begin
                  if (wall) begin
                     game_over_q <= 1'b1;
                     state_q     <= ST_OVER;
                  end else begin
                     next_x_q       <= cand_x;
                     next_y_q       <= cand_y;
                     eat_q          <= eat_d;
                     map_tick_q     <= 1'b1;
                     body_push_q    <= 1'b1;
                     map_eat_q      <= grow_d;
                     map_will_pop_q <= !grow_d;
                     state_q        <= ST_COMMIT;
                  end
               end
               ST_COMMIT: begin
                  head_x_q      <= next_x_q;
                  head_y_q      <= next_y_q;
                  len_q         <= len_q + LW'(map_eat_q);
                  apple_eaten_q <= eat_q;
                  game_over_q   <= self_hit_now;
                  state_q       <= self_hit_now ? ST_OVER : ST_IDLE;
               end
               ST_CLEAR: begin
                  heading_q   <= DIR_RIGHT;
                  head_x_q    <= XW'(START_X);
                  head_y_q    <= YW'(START_Y);
                  next_x_q    <= XW'(START_X);
                  next_y_q    <= YW'(START_Y);
                  len_q       <= '0;
                  eat_q       <= 1'b0;
                  game_over_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
               default: state_q <= state_q;
            endcase
         end
      end
   end

   assign head_xy      = {head_x_q, head_y_q};
   assign body_din     = {head_x_q, head_y_q};
   assign next_x       = next_x_q;
   assign next_y       = next_y_q;
   assign map_tick     = map_tick_q;
   assign map_eat      = map_eat_q;
   assign map_will_pop = map_will_pop_q;
   assign body_push    = body_push_q;
   assign tail_valid   = body_count != '0;
   assign body_pop     = map_will_pop_q && tail_valid;
   assign sub_clear    = sub_clear_q;
   assign apple_eaten  = apple_eaten_q;
   assign game_over    = game_over_q;
   assign busy         = !(state_q == ST_IDLE || state_q == ST_OVER);

endmodule

// File: tb/tb_snake_step_ctrl.sv
// tb_snake_step_ctrl: directed self-checking bench for snake_step_ctrl.
module tb_snake_step_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        step_req = 1'b0;
   logic [1:0]  dir = 2'b01;
   logic        restart = 1'b0;
   logic [10:0] apple_xy;
   logic        self_hit_now = 1'b0;
   logic [6:0]  body_count = '0;
   logic [10:0] head_xy, body_din;
   logic [5:0]  next_x;
   logic [4:0]  next_y;
   logic        map_tick, map_eat, map_will_pop, tail_valid, body_push, body_pop;
   logic        sub_clear, apple_eaten, game_over, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int hx = 20, hy = 15, len = 0, cnt = 0, ax = 5, ay = 5;
   logic [1:0] hd = 2'b01;
   logic over = 1'b0;

   assign apple_xy = {6'(ax), 5'(ay)};

   always #5 clk = ~clk;

   snake_step_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .step_req     (step_req),
      .dir          (dir),
      .restart      (restart),
      .apple_xy     (apple_xy),
      .self_hit_now (self_hit_now),
      .body_count   (body_count),
      .head_xy      (head_xy),
      .next_x       (next_x),
      .next_y       (next_y),
      .map_tick     (map_tick),
      .map_eat      (map_eat),
      .map_will_pop (map_will_pop),
      .tail_valid   (tail_valid),
      .body_push    (body_push),
      .body_pop     (body_pop),
      .body_din     (body_din),
      .sub_clear    (sub_clear),
      .apple_eaten  (apple_eaten),
      .game_over    (game_over),
      .busy         (busy)
   );

   function automatic logic [10:0] xy(input int x, input int y);
      return {6'(x), 5'(y)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic spawn_model();
      hx = 20; hy = 15; hd = 2'b01; len = 0; cnt = 0; over = 1'b0;
      body_count = '0;
   endtask

   // Issues one step request and checks every phase against the bench's own snake model.
   task automatic step(input logic [1:0] d, input logic hit, input logic feed);
      logic [1:0] nh;
      int nx, ny;
      logic eat, grow, pop;
      nh = (d == (hd ^ 2'b10)) ? hd : d;
      nx = hx + int'(nh == 2'b01) - int'(nh == 2'b11);
      ny = hy + int'(nh == 2'b10) - int'(nh == 2'b00);
      if (feed) begin ax = nx; ay = ny; end
      eat  = (nx == ax) && (ny == ay);
      grow = eat && (len < 64);
      pop  = !grow && (cnt != 0);
      @(negedge clk); dir = d; step_req = 1'b1;
      @(negedge clk); step_req = 1'b0;
      if (over) begin
         chk("over_busy", busy, 0);
         chk("over_tick", map_tick, 0);
         @(negedge clk);
         chk("over_tick2", map_tick, 0);
         chk("over_push", body_push, 0);
         chk("over_level", game_over, 1);
         return;
      end
      chk("calc_busy", busy, 1);
      chk("calc_tick", map_tick, 0);
      @(negedge clk);
      hd = nh;
      if (nx < 0 || nx >= 40 || ny < 0 || ny >= 30) begin
         chk("wall_over", game_over, 1);
         chk("wall_tick", map_tick, 0);
         chk("wall_push", body_push, 0);
         chk("wall_busy", busy, 0);
         over = 1'b1;
         return;
      end
      chk("tick", map_tick, 1);
      chk("push", body_push, 1);
      chk("next_x", next_x, nx);
      chk("next_y", next_y, ny);
      chk("din", body_din, xy(hx, hy));
      chk("map_eat", map_eat, grow);
      chk("will_pop", map_will_pop, !grow);
      chk("pop", body_pop, pop);
      self_hit_now = hit;
      @(negedge clk); self_hit_now = 1'b0;
      hx = nx; hy = ny; len += int'(grow); cnt += 1 - int'(pop); over = hit;
      body_count = 7'(cnt);
      chk("head", head_xy, xy(hx, hy));
      chk("ate", apple_eaten, eat);
      chk("go", game_over, hit);
      chk("idle_busy", busy, 0);
      chk("tick_off", map_tick, 0);
   endtask

   // Called at a negedge; restart is sampled by the following posedge.
   task automatic do_restart();
      restart = 1'b1;
      @(negedge clk); restart = 1'b0;
      chk("clr_pulse", sub_clear, 1);
      chk("clr_busy", busy, 1);
      chk("clr_tick", map_tick, 0);
      @(negedge clk);
      chk("clr_end", sub_clear, 0);
      chk("spawn_head", head_xy, xy(20, 15));
      chk("spawn_go", game_over, 0);
      chk("spawn_busy", busy, 0);
      spawn_model();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_head", head_xy, xy(20, 15));
      chk("rst_nx", next_x, 20);
      chk("rst_ny", next_y, 15);
      chk("rst_strobes", {map_tick, map_eat, map_will_pop, body_push, body_pop, apple_eaten}, 0);
      chk("rst_clear", sub_clear, 0);
      chk("rst_go", game_over, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tail", tail_valid, 0);
      // plain moves, reversal suppression, turn
      step(2'b01, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0);
      step(2'b00, 1'b0, 1'b0);
      do_restart();
      // apple on the first cell, then a pop once the body is non-empty
      ax = 21; ay = 15;
      step(2'b01, 1'b0, 1'b0);
      @(negedge clk);
      chk("ate_pulse", apple_eaten, 0);
      ax = 5; ay = 5;
      step(2'b10, 1'b0, 1'b0);
      // drive to (39,10) then hit the right wall; later requests are ignored
      repeat (18) step(2'b01, 1'b0, 1'b0);
      repeat (6) step(2'b00, 1'b0, 1'b0);
      chk("at_edge", head_xy, xy(39, 10));
      step(2'b01, 1'b0, 1'b0);
      step(2'b00, 1'b0, 1'b0);
      do_restart();
      // circle a 2x2 square eating every step: 64 grow, the 65th is a plain move
      for (int i = 0; i < 65; i++) step(2'(i + 1), 1'b0, 1'b1);
      ax = 5; ay = 5;
      // self collision reported by the map during COMMIT
      step(2'b00, 1'b1, 1'b0);
      do_restart();
      // restart while the step is in CALC
      @(negedge clk); dir = 2'b01; step_req = 1'b1;
      @(negedge clk); step_req = 1'b0;
      chk("mid_calc_busy", busy, 1);
      do_restart();
      // asynchronous reset during COMMIT
      @(negedge clk); dir = 2'b01; step_req = 1'b1;
      @(negedge clk); step_req = 1'b0;
      @(negedge clk);
      chk("pre_rst_tick", map_tick, 1);
      reset_n = 1'b0;
      #1;
      chk("arst_strobes", {map_tick, map_will_pop, body_push, sub_clear}, 0);
      chk("arst_busy", busy, 0);
      chk("arst_head", head_xy, xy(20, 15));
      @(negedge clk); reset_n = 1'b1;
      spawn_model();
      step(2'b01, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/snake_step_ctrl.md
# snake_step_ctrl

Per-step game sequencer for the snake core. On each game-rate `step_req` it latches the requested direction, computes the next head cell and checks walls and apple. It then drives the occupancy map's `tick`/`eat`/`will_pop` strobes and the body FIFO's push/pop, and freezes the game on wall or self collision. It sits between the game-rate divider and input logic on one side, and the occupancy map and body FIFO on the other.

## Interface
- `XW`, 6, x coordinate width
- `YW`, 5, y coordinate width
- `GRID_W`, 40, columns
- `GRID_H`, 30, rows
- `MAX_LEN`, 64, max body segments held in FIFO (excluding head)
- `LW`, 7, length/count width (holds 0..MAX_LEN)
- `START_X`, 20, `START_Y`, 15, spawn head cell

- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `step_req`  in  1  one-cycle game-step pulse
- `dir`  in  2  requested heading: 00 up, 01 right, 10 down, 11 left
- `restart`  in  1  one-cycle new-game pulse
- `apple_xy`  in  XW+YW  {x,y} of current apple
- `self_hit_now`  in  1  from map; valid only while `map_tick`=1
- `body_count`  in  LW  FIFO occupancy
- `head_xy`  out  XW+YW  current head {x,y}, registered
- `next_x` / `next_y`  out  XW / YW  candidate head cell, registered
- `map_tick`, `map_eat`, `map_will_pop`  out  1  map strobes
- `tail_valid`  out  1  `body_count`≠0
- `body_push`, `body_pop`  out  1  FIFO strobes
- `body_din`  out  XW+YW  equals `head_xy`
- `sub_clear`  out  1  one-cycle clear to map and FIFO
- `apple_eaten`  out  1  one-cycle pulse
- `game_over`  out  1  level
- `busy`  out  1  high outside IDLE/OVER

## Operation
- States: IDLE, CALC, COMMIT, OVER, CLEAR.
- IDLE: on `step_req`, latch `dir` and go to CALC.
  - If `dir` is the opposite of the current heading, it is ignored and the heading is kept.
- CALC: form next cell with one extra bit of width.
  - Wall hit when x=0 moving left, x=GRID_W-1 moving right, y=0 moving up, or y=GRID_H-1 moving down. No wrap-around.
  - Wall hit → OVER; no `map_tick` or FIFO strobes are issued.
  - Otherwise register `next_x`/`next_y` and eat = (next == `apple_xy`), then go to COMMIT.
- COMMIT (exactly one cycle): assert `map_tick` and `body_push`.
  - `map_eat` = eat && length<MAX_LEN. Eating at MAX_LEN behaves as a normal move.
  - `map_will_pop` = !`map_eat`.
  - `body_pop` = `map_will_pop` && `tail_valid`.
  - Sample `self_hit_now` in this cycle.
  - Next cycle: `head_xy`←next. Length increments if `map_eat`. `apple_eaten` pulses if eat.
  - If hit sampled → OVER, else → IDLE.
- OVER: `game_over`=1; `step_req` is ignored.
- `restart` (any state, priority over `step_req`) → CLEAR.
  - CLEAR: `sub_clear`=1 for one cycle.
  - Head←(START_X,START_Y), heading←right, length←0, `game_over`←0, then → IDLE.
- `step_req` arriving outside IDLE is dropped, not queued.
- `body_push` always fires in COMMIT. The body holds the previous head; length excludes the head.

## Timing
- Reset (`reset_n`=0, async): state IDLE, head=(START_X,START_Y), heading=right, `next_x`/`next_y`=head, length=0.
  - All strobes 0; `game_over`=0, `busy`=0, `sub_clear`=0.
- `step_req` sampled at edge N → CALC in N+1 → `map_tick` high in cycle N+2 → new `head_xy` and IDLE in N+3.
- Minimum step period is 3 cycles; faster requests are dropped.
- Wall: OVER and `game_over`=1 from N+2.
- Self-hit: `game_over`=1 from N+3. The map has already accepted the tick; the game is frozen regardless.
- `restart` at edge M: `sub_clear` high in M+1, IDLE with spawn values in M+2.
- `reset_n` asserted mid-step aborts immediately; no strobe remains high.

## Structure
- Shared header `snake_defs.vh`: direction codes, state encodings, default GRID_W/GRID_H/START_X/START_Y/MAX_LEN.
- Optional combinational sub-module `snake_next_cell`: current head + heading → next cell + wall flag. Everything else is a single FSM module.

## Test plan
- Reset release, `dir`=01, `step_req`: `map_tick` 2 cycles later with next=(21,15), `body_push` with din=(20,15), `map_will_pop`=1, `body_pop`=0 (count 0); head=(21,15).
- Heading right, `dir`=11: move ignored as reversal → head=(22,15); `dir`=00 → (22,14).
- Head (39,10) heading right, `step_req`: no `map_tick`, `game_over`=1 at N+2; later `step_req` causes no strobes.
- `apple_xy`=(21,15) on first step: `map_eat`=1, `body_pop`=0, `apple_eaten` pulse, length 0→1; length at MAX_LEN with apple → `map_eat`=0, length unchanged.
- `self_hit_now`=1 during COMMIT → `game_over`=1 next cycle, `busy`=0.
- `restart` in OVER, and again mid-CALC: `sub_clear` one cycle, head=(20,15), heading right, length 0, `game_over`=0.
